// File: rtl/axppa_pkg.sv
// Shared types, default widths and the error-distance helper for the adder error monitor.
package axppa_pkg;

  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    REPORT
  } state_e;

  // |exact - approx| using one extra bit so the sign of the difference is never lost.
  function automatic logic [DW_DEF:0] ed_abs(input logic [DW_DEF:0] exact,
                                             input logic [DW_DEF:0] approx);
    logic [DW_DEF+1:0] diff;
    diff = {1'b0, exact} - {1'b0, approx};
    if (diff[DW_DEF+1]) begin
      diff = -diff;
    end
    return diff[DW_DEF:0];
  endfunction

endpackage

// File: rtl/axppa_ed_stage.sv
// Stage 1 of the monitor pipeline: registers the error distance of an accepted pair plus a valid.
module axppa_ed_stage
  import axppa_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_fire,
  input  logic [DW:0]   exact_res,
  input  logic [DW:0]   approx_res,
  output logic          ed_valid,
  output logic [DW:0]   ed
);

  logic [DW:0] ed_d;

  generate
    if (DW == DW_DEF) begin : g_pkg_abs
      assign ed_d = ed_abs(exact_res, approx_res);
    end else begin : g_local_abs
      logic [DW+1:0] diff;
      always_comb begin
        diff = {1'b0, exact_res} - {1'b0, approx_res};
        if (diff[DW+1]) begin
          diff = -diff;
        end
        ed_d = diff[DW:0];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed_valid <= 1'b0;
      ed       <= '0;
    end else begin
      ed_valid <= in_fire;
      if (in_fire) begin
        ed <= ed_d;
      end
    end
  end

endmodule

// File: rtl/axppa_error_monitor.sv
// Accuracy monitor for exact vs approximate prefix adders: error count, ED sum and ED max per run.
// Optional AXPPA_MAX_IDX_EN adds max_idx, the index of the first sample reaching ed_max.
module axppa_error_monitor
  import axppa_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_samples,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW:0]           exact_res,
  input  logic [DW:0]           approx_res,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
`ifdef AXPPA_MAX_IDX_EN
  output logic [CNT_W-1:0]      max_idx,
`endif
  output logic [CNT_W-1:0]      err_count,
  output logic [DW+CNT_W:0]     ed_sum,
  output logic [DW:0]           ed_max
);

  localparam int unsigned SumW = DW + 1 + CNT_W;

  state_e           state;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_q;
  logic             in_fire;
  logic             ed_valid;
  logic [DW:0]      ed;
  logic             run_start;

  assign in_ready     = (state == RUN) && (acc_q < num_q);
  assign in_fire      = in_valid && in_ready;
  assign busy         = (state != IDLE);
  assign result_valid = (state == REPORT);
  assign run_start    = (state == IDLE) && start;

  axppa_ed_stage #(
    .DW (DW)
  ) u_ed_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_fire    (in_fire),
    .exact_res  (exact_res),
    .approx_res (approx_res),
    .ed_valid   (ed_valid),
    .ed         (ed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      num_q <= '0;
      acc_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            num_q <= num_samples;
            acc_q <= '0;
            state <= (num_samples == '0) ? REPORT : RUN;
          end
        end
        RUN: begin
          if (in_fire) begin
            acc_q <= acc_q + CNT_W'(1);
            if (acc_q + CNT_W'(1) == num_q) begin
              state <= DRAIN;
            end
          end
        end
        // The last sample leaves stage 1 on this edge, so the stats are final next cycle.
        DRAIN: state <= REPORT;
        REPORT: begin
          if (result_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      ed_sum    <= '0;
      ed_max    <= '0;
    end else if (run_start) begin
      err_count <= '0;
      ed_sum    <= '0;
      ed_max    <= '0;
    end else if (ed_valid) begin
      if (ed != '0) begin
        err_count <= err_count + CNT_W'(1);
      end
      ed_sum <= ed_sum + SumW'(ed);
      if (ed > ed_max) begin
        ed_max <= ed;
      end
    end
  end

`ifdef AXPPA_MAX_IDX_EN
  logic [CNT_W-1:0] proc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_q  <= '0;
      max_idx <= '0;
    end else if (run_start) begin
      proc_q  <= '0;
      max_idx <= '0;
    end else if (ed_valid) begin
      proc_q <= proc_q + CNT_W'(1);
      // Strictly greater keeps the index of the first sample that hit the maximum.
      if (ed > ed_max) begin
        max_idx <= proc_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axppa_error_monitor.sv
// Directed self-checking bench for axppa_error_monitor (define AXPPA_MAX_IDX_EN to check max_idx).
module tb_axppa_error_monitor;

  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   num_samples = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DW:0]        exact_res = '0;
  logic [DW:0]        approx_res = '0;
  logic               busy;
  logic               result_valid;
  logic               result_ready = 1'b0;
  logic [CNT_W-1:0]   err_count;
  logic [DW+CNT_W:0]  ed_sum;
  logic [DW:0]        ed_max;
`ifdef AXPPA_MAX_IDX_EN
  logic [CNT_W-1:0]   max_idx;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axppa_error_monitor #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .exact_res    (exact_res),
    .approx_res   (approx_res),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
`ifdef AXPPA_MAX_IDX_EN
    .max_idx      (max_idx),
`endif
    .err_count    (err_count),
    .ed_sum       (ed_sum),
    .ed_max       (ed_max)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [CNT_W-1:0] num);
    num_samples = num;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one pair and hold it until accepted (bounded).
  task automatic send(input logic [DW:0] e, input logic [DW:0] a);
    int n;
    exact_res  = e;
    approx_res = a;
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", in_ready, 1);
    tick();
  endtask

  task automatic finish_report(input string tag, input logic [63:0] ec, input logic [63:0] es,
                               input logic [63:0] em, input logic [63:0] mi);
    int n;
    n = 0;
    while (!result_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_rv"}, result_valid, 1);
    chk({tag, "_err_count"}, err_count, ec);
    chk({tag, "_ed_sum"}, ed_sum, es);
    chk({tag, "_ed_max"}, ed_max, em);
`ifdef AXPPA_MAX_IDX_EN
    chk({tag, "_max_idx"}, max_idx, mi);
`else
    if (mi > 64'hFFFF_FFFF) $display("note: unused idx %0h", mi);
`endif
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk({tag, "_rv_drop"}, result_valid, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold_sum"}, ed_sum, es);
  endtask

  initial begin
    int k;
    int cyc;
    int cnt;
    logic xfer;

    // Reset state
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_ed_sum", ed_sum, 0);
    chk("rst_ed_max", ed_max, 0);
    rst_n = 1'b1;
    tick();

    // 1. Reset mid-run
    start_run(8);
    chk("t1_busy", busy, 1);
    chk("t1_ready", in_ready, 1);
    send(17'd3, 17'd1);
    send(17'd0, 17'd5);
    send(17'd2, 17'd2);
    in_valid = 1'b0;
    tick();
    chk("t1_pre_err", err_count, 2);
    chk("t1_pre_sum", ed_sum, 7);
    rst_n = 1'b0;
    #1;
    chk("t1_busy0", busy, 0);
    chk("t1_rv0", result_valid, 0);
    chk("t1_ready0", in_ready, 0);
    chk("t1_err0", err_count, 0);
    chk("t1_sum0", ed_sum, 0);
    chk("t1_max0", ed_max, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_still_idle", busy, 0);

    // 2. Exact equals approx
    start_run(4);
    for (int i = 0; i < 4; i++) send(17'h0_1234, 17'h0_1234);
    in_valid = 1'b0;
    chk("t2_drain_ready", in_ready, 0);
    chk("t2_drain_rv", result_valid, 0);
    chk("t2_drain_busy", busy, 1);
    tick();
    chk("t2_report_rv", result_valid, 1);
    finish_report("t2", 0, 0, 0, 0);

    // 3. Mixed errors
    start_run(3);
    send(17'h1_0000, 17'h0_FFFF);
    send(17'd5, 17'd9);
    send(17'd7, 17'd7);
    in_valid = 1'b0;
    finish_report("t3", 2, 5, 4, 1);

    // 4. Back-pressure on both ports; ED of sample k is 63*k
    start_run(5);
    k = 0;
    cyc = 0;
    while (k < 5 && cyc < 200) begin
      in_valid   = 1'($urandom_range(0, 1));
      exact_res  = 17'(k * 100);
      approx_res = 17'(k * 37);
      xfer = in_valid && in_ready;
      tick();
      if (xfer) k++;
      cyc++;
    end
    chk("t4_transfers", k, 5);
    // Junk offered while not ready must be ignored
    in_valid   = 1'b1;
    exact_res  = 17'h1_FFFF;
    approx_res = 17'h0_0000;
    chk("t4_not_ready", in_ready, 0);
    tick();
    tick();
    chk("t4_rv", result_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_rv", result_valid, 1);
      chk("t4_hold_max", ed_max, 252);
    end
    in_valid = 1'b0;
    finish_report("t4", 4, 630, 252, 4);

    // 5. Zero-length run, then start ignored while running
    start_run(0);
    chk("t5_zero_rv", result_valid, 1);
    finish_report("t5a", 0, 0, 0, 0);
    start_run(2);
    num_samples = 7;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_run_busy", busy, 1);
    send(17'd1, 17'd0);
    send(17'd1, 17'd0);
    in_valid = 1'b0;
    chk("t5_stop_after_2", in_ready, 0);
    finish_report("t5b", 2, 2, 1, 0);

    // 6. Max-range, back-to-back
    start_run(2);
    send(17'h1_FFFF, 17'h0_0000);
    chk("t6_b2b_ready", in_ready, 1);
    send(17'h1_FFFF, 17'h0_0000);
    in_valid = 1'b0;
    chk("t6_drain_ready", in_ready, 0);
    finish_report("t6", 2, 64'h3_FFFE, 64'h1_FFFF, 0);

    // Full-length run of 2^CNT_W-1 samples
    start_run(16'hFFFF);
    in_valid   = 1'b1;
    exact_res  = 17'd1;
    approx_res = 17'd2;
    cnt = 0;
    cyc = 0;
    while (busy && !result_valid && cyc < 70000) begin
      if (in_ready) cnt++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("t7_transfers", cnt, 65535);
    finish_report("t7", 65535, 65535, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
